// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle for the SDRAM port arbiter: both requester handshakes plus the
// controller-side user port. The "master" modport is the arbiter's view and
// the "slave" modport is the view of the requesters and controller around it.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 128
);
    logic              ivga_req;
    logic [ADDR_W-1:0] ivga_addr;
    logic [DATA_W-1:0] ovga_data;
    logic              ovga_ack;

    logic              iwr_req;
    logic [ADDR_W-1:0] iwr_addr;
    logic [DATA_W-1:0] iwr_data;
    logic              owr_ack;

    logic              osd_req;
    logic              osd_we;
    logic [ADDR_W-1:0] osd_addr;
    logic [DATA_W-1:0] osd_wdata;
    logic [DATA_W-1:0] isd_rdata;
    logic              isd_ack;

    modport master (
        input  ivga_req, ivga_addr, iwr_req, iwr_addr, iwr_data, isd_rdata, isd_ack,
        output ovga_data, ovga_ack, owr_ack, osd_req, osd_we, osd_addr, osd_wdata
    );

    modport slave (
        output ivga_req, ivga_addr, iwr_req, iwr_addr, iwr_data, isd_rdata, isd_ack,
        input  ovga_data, ovga_ack, owr_ack, osd_req, osd_we, osd_addr, osd_wdata
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter for the SDRAM controller user port.
// VGA line fetches have priority; a starvation counter forces the frame
// writer through after STARVE_LIMIT consecutive VGA grants taken while it
// waits. One transaction is outstanding at a time.
// Optional build macro ARB_STATS_EN adds read/write/forced-write counters.
//
// state     | meaning
// IDLE      | no transaction, sampling requests
// GRANT_VGA | read issued to controller, waiting for isd_ack
// GRANT_WR  | write issued to controller, waiting for isd_ack
// DONE      | requester ack visible, requests not sampled
module sdram_port_arbiter #(
    parameter int ADDR_W       = 22,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic iclk_50,
    input  logic ireset,
    sdram_port_arbiter_if.master bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0] ostat_vga,
    output logic [15:0] ostat_wr,
    output logic [15:0] ostat_forced
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_VGA,
        GRANT_WR,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic              starved;
    logic              take_vga;
    logic              take_wr;
    logic              done_vga;
    logic              done_wr;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] rd_word;

    assign starved = bus.iwr_req && (starve_cnt == CNT_MAX);
    assign rd_word = bus.isd_rdata;

    // State register.
    always_ff @(posedge iclk_50) begin
        if (ireset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and grant/completion strobes.
    always_comb begin
        state_nxt  = state;
        take_vga   = 1'b0;
        take_wr    = 1'b0;
        done_vga   = 1'b0;
        done_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ivga_req && !starved) begin
                    take_vga  = 1'b1;
                    state_nxt = GRANT_VGA;
                end else if (bus.iwr_req) begin
                    take_wr   = 1'b1;
                    state_nxt = GRANT_WR;
                end
            end
            GRANT_VGA: begin
                if (bus.isd_ack) begin
                    done_vga  = 1'b1;
                    state_nxt = DONE;
                end
            end
            GRANT_WR: begin
                if (bus.isd_ack) begin
                    done_wr   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        grant_addr = take_wr ? bus.iwr_addr : bus.ivga_addr;
    end

    // Count VGA grants taken over a waiting writer; any write grant or an
    // idle cycle with no writer pending resets the run.
    always_ff @(posedge iclk_50) begin
        if (ireset) begin
            starve_cnt <= '0;
        end else if (take_wr) begin
            starve_cnt <= '0;
        end else if (take_vga && bus.iwr_req) begin
            if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else if (state == IDLE && !bus.iwr_req) begin
            starve_cnt <= '0;
        end
    end

    // Registered controller request, latched command and requester acks.
    always_ff @(posedge iclk_50) begin
        if (ireset) begin
            bus.osd_req   <= 1'b0;
            bus.osd_we    <= 1'b0;
            bus.osd_addr  <= '0;
            bus.osd_wdata <= '0;
            bus.ovga_data <= '0;
            bus.ovga_ack  <= 1'b0;
            bus.owr_ack   <= 1'b0;
        end else begin
            bus.ovga_ack <= done_vga;
            bus.owr_ack  <= done_wr;
            if (take_vga || take_wr) begin
                bus.osd_req  <= 1'b1;
                bus.osd_we   <= take_wr;
                bus.osd_addr <= grant_addr;
            end else if (done_vga || done_wr) begin
                bus.osd_req <= 1'b0;
            end
            if (take_wr) begin
                bus.osd_wdata <= bus.iwr_data;
            end
            if (done_vga) begin
                bus.ovga_data <= rd_word;
            end
        end
    end

`ifdef ARB_STATS_EN
    // Free-running 16-bit activity counters; a write grant with VGA also
    // requesting can only happen when the starvation guard fired.
    always_ff @(posedge iclk_50) begin
        if (ireset) begin
            ostat_vga    <= '0;
            ostat_wr     <= '0;
            ostat_forced <= '0;
        end else begin
            if (done_vga) begin
                ostat_vga <= ostat_vga + 16'd1;
            end
            if (done_wr) begin
                ostat_wr <= ostat_wr + 16'd1;
            end
            if (take_wr && bus.ivga_req) begin
                ostat_forced <= ostat_forced + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter. Inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_sdram_port_arbiter;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 128;

    logic iclk_50;
    logic ireset;
    int   n_cmp;
    int   n_err;

    sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_STATS_EN
    logic [15:0] ostat_vga;
    logic [15:0] ostat_wr;
    logic [15:0] ostat_forced;
`endif

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(4)
    ) dut (
        .iclk_50(iclk_50),
        .ireset(ireset),
        .bus(bus)
`ifdef ARB_STATS_EN
        ,
        .ostat_vga(ostat_vga),
        .ostat_wr(ostat_wr),
        .ostat_forced(ostat_forced)
`endif
    );

    initial iclk_50 = 1'b0;
    always #10 iclk_50 = ~iclk_50;

    task automatic step();
        @(posedge iclk_50);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ivga_req  = 1'b0;
        bus.ivga_addr = '0;
        bus.iwr_req   = 1'b0;
        bus.iwr_addr  = '0;
        bus.iwr_data  = '0;
        bus.isd_rdata = '0;
        bus.isd_ack   = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        ireset = 1'b1;
        step();
        step();
        ireset = 1'b0;
        n_cmp++; if (bus.osd_req !== 1'b0) begin n_err++; $display("FAIL reset_osd_req: got %b want 0", bus.osd_req); end
        n_cmp++; if (bus.osd_we !== 1'b0) begin n_err++; $display("FAIL reset_osd_we: got %b want 0", bus.osd_we); end
        n_cmp++; if (bus.osd_addr !== 22'h0) begin n_err++; $display("FAIL reset_osd_addr: got %h want 0", bus.osd_addr); end
        n_cmp++; if (bus.osd_wdata !== 128'h0) begin n_err++; $display("FAIL reset_osd_wdata: got %h want 0", bus.osd_wdata); end
        n_cmp++; if (bus.ovga_data !== 128'h0) begin n_err++; $display("FAIL reset_ovga_data: got %h want 0", bus.ovga_data); end
        n_cmp++; if (bus.ovga_ack !== 1'b0) begin n_err++; $display("FAIL reset_ovga_ack: got %b want 0", bus.ovga_ack); end
        n_cmp++; if (bus.owr_ack !== 1'b0) begin n_err++; $display("FAIL reset_owr_ack: got %b want 0", bus.owr_ack); end
    endtask

    task automatic test_single_read();
        bus.ivga_req  = 1'b1;
        bus.ivga_addr = 22'h00123;
        step();
        n_cmp++; if (bus.osd_req !== 1'b1) begin n_err++; $display("FAIL rd_osd_req: got %b want 1", bus.osd_req); end
        n_cmp++; if (bus.osd_we !== 1'b0) begin n_err++; $display("FAIL rd_osd_we: got %b want 0", bus.osd_we); end
        n_cmp++; if (bus.osd_addr !== 22'h00123) begin n_err++; $display("FAIL rd_osd_addr: got %h want 00123", bus.osd_addr); end
        bus.ivga_addr = 22'h00456;
        step();
        n_cmp++; if (bus.osd_req !== 1'b1) begin n_err++; $display("FAIL rd_osd_req_hold: got %b want 1", bus.osd_req); end
        n_cmp++; if (bus.osd_addr !== 22'h00123) begin n_err++; $display("FAIL rd_osd_addr_hold: got %h want 00123", bus.osd_addr); end
        n_cmp++; if (bus.ovga_ack !== 1'b0) begin n_err++; $display("FAIL rd_early_ack: got %b want 0", bus.ovga_ack); end
        bus.isd_ack   = 1'b1;
        bus.isd_rdata = 128'hABC;
        step();
        bus.isd_ack   = 1'b0;
        bus.isd_rdata = '0;
        bus.ivga_req  = 1'b0;
        n_cmp++; if (bus.ovga_ack !== 1'b1) begin n_err++; $display("FAIL rd_ack_pulse: got %b want 1", bus.ovga_ack); end
        n_cmp++; if (bus.ovga_data !== 128'hABC) begin n_err++; $display("FAIL rd_data: got %h want abc", bus.ovga_data); end
        n_cmp++; if (bus.osd_req !== 1'b0) begin n_err++; $display("FAIL rd_osd_req_drop: got %b want 0", bus.osd_req); end
        n_cmp++; if (bus.owr_ack !== 1'b0) begin n_err++; $display("FAIL rd_no_wr_ack: got %b want 0", bus.owr_ack); end
        step();
        n_cmp++; if (bus.ovga_ack !== 1'b0) begin n_err++; $display("FAIL rd_ack_one_cycle: got %b want 0", bus.ovga_ack); end
        step();
        n_cmp++; if (bus.osd_req !== 1'b0) begin n_err++; $display("FAIL rd_idle_after: got %b want 0", bus.osd_req); end
    endtask

    task automatic test_single_write();
        bus.iwr_req  = 1'b1;
        bus.iwr_addr = 22'h3FFFFF;
        bus.iwr_data = {DATA_W{1'b1}};
        step();
        bus.isd_ack = 1'b1;
        n_cmp++; if (bus.osd_req !== 1'b1) begin n_err++; $display("FAIL wr_osd_req: got %b want 1", bus.osd_req); end
        n_cmp++; if (bus.osd_we !== 1'b1) begin n_err++; $display("FAIL wr_osd_we: got %b want 1", bus.osd_we); end
        n_cmp++; if (bus.osd_addr !== 22'h3FFFFF) begin n_err++; $display("FAIL wr_osd_addr: got %h want 3fffff", bus.osd_addr); end
        n_cmp++; if (bus.osd_wdata !== {DATA_W{1'b1}}) begin n_err++; $display("FAIL wr_osd_wdata: got %h want all ones", bus.osd_wdata); end
        step();
        bus.isd_ack = 1'b0;
        bus.iwr_req = 1'b0;
        n_cmp++; if (bus.owr_ack !== 1'b1) begin n_err++; $display("FAIL wr_ack_pulse: got %b want 1", bus.owr_ack); end
        n_cmp++; if (bus.osd_req !== 1'b0) begin n_err++; $display("FAIL wr_osd_req_drop: got %b want 0", bus.osd_req); end
        n_cmp++; if (bus.ovga_ack !== 1'b0) begin n_err++; $display("FAIL wr_no_vga_ack: got %b want 0", bus.ovga_ack); end
        step();
        n_cmp++; if (bus.owr_ack !== 1'b0) begin n_err++; $display("FAIL wr_ack_one_cycle: got %b want 0", bus.owr_ack); end
        step();
        n_cmp++; if (bus.osd_req !== 1'b0) begin n_err++; $display("FAIL wr_idle_after: got %b want 0", bus.osd_req); end
    endtask

    task automatic test_spurious_ack();
        bus.isd_ack   = 1'b1;
        bus.isd_rdata = 128'h5555;
        step();
        step();
        n_cmp++; if (bus.osd_req !== 1'b0) begin n_err++; $display("FAIL idle_ack_osd_req: got %b want 0", bus.osd_req); end
        n_cmp++; if (bus.ovga_ack !== 1'b0) begin n_err++; $display("FAIL idle_ack_vga: got %b want 0", bus.ovga_ack); end
        n_cmp++; if (bus.owr_ack !== 1'b0) begin n_err++; $display("FAIL idle_ack_wr: got %b want 0", bus.owr_ack); end
        bus.isd_ack   = 1'b0;
        bus.ivga_req  = 1'b1;
        bus.ivga_addr = 22'h00042;
        step();
        bus.ivga_req  = 1'b0;
        bus.isd_ack   = 1'b1;
        bus.isd_rdata = 128'h77;
        step();
        n_cmp++; if (bus.ovga_ack !== 1'b1) begin n_err++; $display("FAIL sp_rd_ack: got %b want 1", bus.ovga_ack); end
        bus.isd_rdata = 128'h99;
        step();
        n_cmp++; if (bus.ovga_ack !== 1'b0) begin n_err++; $display("FAIL done_ack_ignored: got %b want 0", bus.ovga_ack); end
        n_cmp++; if (bus.ovga_data !== 128'h77) begin n_err++; $display("FAIL done_data_kept: got %h want 77", bus.ovga_data); end
        step();
        bus.isd_ack = 1'b0;
        n_cmp++; if (bus.ovga_ack !== 1'b0) begin n_err++; $display("FAIL after_done_ack: got %b want 0", bus.ovga_ack); end
        n_cmp++; if (bus.osd_req !== 1'b0) begin n_err++; $display("FAIL after_done_req: got %b want 0", bus.osd_req); end
    endtask

    task automatic test_drop_mid_grant();
        bus.iwr_req  = 1'b1;
        bus.iwr_addr = 22'h0000AA;
        bus.iwr_data = 128'h1234;
        step();
        bus.iwr_req = 1'b0;
        step();
        n_cmp++; if (bus.osd_req !== 1'b1) begin n_err++; $display("FAIL drop_req_held: got %b want 1", bus.osd_req); end
        bus.isd_ack = 1'b1;
        step();
        bus.isd_ack = 1'b0;
        n_cmp++; if (bus.owr_ack !== 1'b1) begin n_err++; $display("FAIL drop_ack_still: got %b want 1", bus.owr_ack); end
        step();
        step();
    endtask

    task automatic test_starvation();
        logic [9:0] exp_we;
        exp_we = 10'b1000010000;
        clear_inputs();
        ireset = 1'b1;
        step();
        ireset = 1'b0;
        bus.ivga_req  = 1'b1;
        bus.ivga_addr = 22'h00100;
        bus.iwr_req   = 1'b1;
        bus.iwr_addr  = 22'h00200;
        bus.iwr_data  = 128'hFEED;
        bus.isd_rdata = 128'hBEEF;
        for (int g = 0; g < 10; g++) begin
            step();
            n_cmp++; if (bus.osd_req !== 1'b1) begin n_err++; $display("FAIL starve_req[%0d]: got %b want 1", g, bus.osd_req); end
            n_cmp++; if (bus.osd_we !== exp_we[g]) begin n_err++; $display("FAIL starve_order[%0d]: got we=%b want %b", g, bus.osd_we, exp_we[g]); end
            n_cmp++; if (bus.osd_addr !== (exp_we[g] ? 22'h00200 : 22'h00100)) begin n_err++; $display("FAIL starve_addr[%0d]: got %h", g, bus.osd_addr); end
            bus.isd_ack = 1'b1;
            step();
            bus.isd_ack = 1'b0;
            n_cmp++; if (bus.ovga_ack !== !exp_we[g]) begin n_err++; $display("FAIL starve_vga_ack[%0d]: got %b want %b", g, bus.ovga_ack, !exp_we[g]); end
            n_cmp++; if (bus.owr_ack !== exp_we[g]) begin n_err++; $display("FAIL starve_wr_ack[%0d]: got %b want %b", g, bus.owr_ack, exp_we[g]); end
            step();
            if (g == 9) begin
                bus.ivga_req = 1'b0;
                bus.iwr_req  = 1'b0;
            end
        end
        step();
        n_cmp++; if (bus.osd_req !== 1'b0) begin n_err++; $display("FAIL starve_end_idle: got %b want 0", bus.osd_req); end
`ifdef ARB_STATS_EN
        n_cmp++; if (ostat_vga !== 16'd8) begin n_err++; $display("FAIL stat_vga: got %0d want 8", ostat_vga); end
        n_cmp++; if (ostat_wr !== 16'd2) begin n_err++; $display("FAIL stat_wr: got %0d want 2", ostat_wr); end
        n_cmp++; if (ostat_forced !== 16'd2) begin n_err++; $display("FAIL stat_forced: got %0d want 2", ostat_forced); end
`endif
    endtask

    task automatic test_reset_mid();
        bus.ivga_req  = 1'b1;
        bus.ivga_addr = 22'h00321;
        bus.iwr_req   = 1'b1;
        bus.iwr_addr  = 22'h00654;
        step();
        bus.iwr_req = 1'b0;
        n_cmp++; if (dut.starve_cnt !== 3'd1) begin n_err++; $display("FAIL rstmid_cnt_before: got %0d want 1", dut.starve_cnt); end
        step();
        ireset = 1'b1;
        step();
        ireset       = 1'b0;
        bus.ivga_req = 1'b0;
        n_cmp++; if (bus.osd_req !== 1'b0) begin n_err++; $display("FAIL rstmid_osd_req: got %b want 0", bus.osd_req); end
        n_cmp++; if (bus.ovga_ack !== 1'b0) begin n_err++; $display("FAIL rstmid_vga_ack: got %b want 0", bus.ovga_ack); end
        n_cmp++; if (dut.starve_cnt !== 3'd0) begin n_err++; $display("FAIL rstmid_cnt: got %0d want 0", dut.starve_cnt); end
        bus.isd_ack   = 1'b1;
        bus.isd_rdata = 128'hDEAD;
        step();
        bus.isd_ack = 1'b0;
        n_cmp++; if (bus.ovga_ack !== 1'b0) begin n_err++; $display("FAIL rstmid_late_ack: got %b want 0", bus.ovga_ack); end
        n_cmp++; if (bus.ovga_data !== 128'h0) begin n_err++; $display("FAIL rstmid_data: got %h want 0", bus.ovga_data); end
        step();
        n_cmp++; if (bus.owr_ack !== 1'b0) begin n_err++; $display("FAIL rstmid_wr_ack: got %b want 0", bus.owr_ack); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_read();
        test_single_write();
        test_spurious_ack();
        test_drop_mid_grant();
        test_starvation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
